qpsk_frame_sched: RTL and testbench
===================================

# qpsk_frame_sched

Frame scheduler in front of the QPSK symbol repeater. It shares the repeater's single 32-bit AXI-Stream input between two requesters, a preamble source and a payload source, and sequences each frame as: preamble words, then payload words, then a run of zero-valued guard words. Frame lengths are latched per frame. The block adds no data latency: the selected source is muxed straight through to the repeater.

## Interface
Parameters:
- DW, 32: data width of all stream ports.
- LEN_W, 16: width of the length inputs and of the word counter.

Ports:
- clk  in  1  single clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  frame request; sampled only in IDLE.
- pre_len  in  LEN_W  preamble word count; latched on accepted start.
- pay_len  in  LEN_W  payload word count; latched on accepted start.
- gap_len  in  LEN_W  guard word count; latched on accepted start.
- pre_tdata  in  DW  preamble source data.
- pre_tvalid  in  1  preamble source valid.
- pre_tready  out  1  preamble source ready.
- pay_tdata  in  DW  payload source data.
- pay_tvalid  in  1  payload source valid.
- pay_tready  out  1  payload source ready.
- out_tdata  out  DW  data to the repeater input.
- out_tvalid  out  1  valid to the repeater.
- out_tready  in  1  ready from the repeater.
- busy  out  1  high in every state except IDLE.
- frame_done  out  1  one-cycle pulse when a frame completes.
- sched_state  out  4  one-hot state, for debug.

## Operation
- States are one-hot: IDLE=0001, PRE=0010, PAY=0100, GAP=1000.
- A beat is the handshake out_tvalid && out_tready. The word counter wcnt counts beats in the current phase and clears on every phase change.
- IDLE:
  - out_tvalid=0, pre_tready=0, pay_tready=0.
  - When start=1, latch the three lengths and go to the first phase with a nonzero length, in order PRE, PAY, GAP.
  - If all three lengths are 0, stay in IDLE and pulse frame_done on the next cycle.
- PRE:
  - out_tdata=pre_tdata, out_tvalid=pre_tvalid, pre_tready=out_tready, pay_tready=0.
- PAY:
  - out_tdata=pay_tdata, out_tvalid=pay_tvalid, pay_tready=out_tready, pre_tready=0.
- GAP:
  - out_tdata=0, out_tvalid=1, both source readies 0.
- Phase exit: a beat with wcnt==len-1 ends the phase. The next state is the next phase with a nonzero length; if none remains, go to IDLE and assert frame_done in the cycle after that final beat.
- Zero-length phases are skipped and consume no cycles.
- start is ignored while busy=1. start in the same cycle that frame_done is high is accepted, since the block is in IDLE then.
- The non-selected source always sees tready=0, so its data is held by AXI rules.

## Timing
- Reset values: state IDLE, wcnt=0, latched lengths 0, out_tvalid=0, pre_tready=0, pay_tready=0, busy=0, frame_done=0, out_tdata=0.
- Data path is combinational: 0 cycles from source to out_tdata. Ready is combinational: out_tready to the selected source tready.
- The first beat of a frame can occur 1 cycle after start is sampled.
- Back-to-back frames: IDLE lasts at least 1 cycle between frames.
- Frame length in beats is exactly pre_len+pay_len+gap_len.
- Reset asserted mid-frame: on the next edge the block returns to IDLE with all readies and valid low, and no frame_done is issued. A beat in that same cycle is still completed downstream.
- out_tvalid in PRE or PAY follows the source and may drop. GAP holds out_tvalid=1 until its last beat.

## Configuration
- QPSK_SCHED_STATS_EN defined:
  - Adds output frame_cnt [15:0], reset to 0, incremented on every frame_done and wrapping from 0xFFFF to 0.
  - Adds output stall_cnt [31:0], counting cycles in PRE or PAY with out_tvalid=0, saturating at 0xFFFFFFFF.
- Not defined: neither port nor its counters exist, and the behaviour of all other ports is identical.

## Structure
- Package qpsk_sched_pkg holds:
  - the state encodings (IDLE, PRE, PAY, GAP);
  - the phase-select function for the next nonzero phase;
  - the default LEN_W.
- One sub-module, sched_phase_cnt: holds wcnt, its clear and increment, and the last-beat compare (wcnt==len-1), parameterised by LEN_W.
- Muxing and the FSM stay in the top level.

## Test plan
- pre_len=2, pay_len=3, gap_len=4, sources always valid, out_tready=1 -> out beats: 2 preamble words, 3 payload words, then 4 zeros. frame_done pulses 1 cycle after beat 9. busy is high for 9 cycles.
- pre_len=0, pay_len=2, gap_len=0 -> PRE is skipped and pre_tready never goes high. Exactly 2 payload beats, then IDLE.
- All lengths 0 with a start pulse -> no beats; frame_done pulses 1 cycle later and busy stays 0.
- out_tready toggling 1,0,1,0 during PAY with pay_len=4 -> pay_tready mirrors out_tready and exactly 4 payload words are consumed, in order.
- Reset asserted after 1 of 3 payload beats -> the next cycle is IDLE with all readies 0 and no frame_done. A following start with pay_len=1 sends 1 beat.
- With QPSK_SCHED_STATS_EN defined, 3 frames -> frame_cnt=3. With frame_cnt preloaded near 0xFFFF, wrap-around to 0 is checked.

Source files
------------

// File: rtl/qpsk_sched_pkg.sv
// Shared definitions for the QPSK frame scheduler: one-hot state codes,
// the default length width and the "next nonzero phase" selector.
package qpsk_sched_pkg;

  localparam int LEN_W_DEF = 16;

  typedef enum logic [3:0] {
    ST_IDLE = 4'b0001,
    ST_PRE  = 4'b0010,
    ST_PAY  = 4'b0100,
    ST_GAP  = 4'b1000
  } sched_state_t;

  // Phase that follows cur, skipping phases whose length is zero.
  // From IDLE this picks the first phase of a frame; IDLE means the frame is over.
  function automatic sched_state_t next_phase(input sched_state_t cur,
                                              input logic pre_nz,
                                              input logic pay_nz,
                                              input logic gap_nz);
    next_phase = ST_IDLE;
    case (cur)
      ST_IDLE: begin
        if (pre_nz)      next_phase = ST_PRE;
        else if (pay_nz) next_phase = ST_PAY;
        else if (gap_nz) next_phase = ST_GAP;
      end
      ST_PRE: begin
        if (pay_nz)      next_phase = ST_PAY;
        else if (gap_nz) next_phase = ST_GAP;
      end
      ST_PAY: begin
        if (gap_nz)      next_phase = ST_GAP;
      end
      default: next_phase = ST_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/sched_phase_cnt.sv
// Per-phase word counter: counts beats of the current phase and flags the
// beat that closes it. The counter clears itself on that closing beat, so it
// always starts the next phase at zero.
module sched_phase_cnt
  import qpsk_sched_pkg::*;
#(
  parameter int LEN_W = LEN_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             beat,
  input  logic [LEN_W-1:0] len,
  output logic             last
);

  logic [LEN_W-1:0] wcnt;

  // Closing beat of a phase is the one taken while wcnt == len-1.
  assign last = (wcnt == (len - LEN_W'(1)));

  // Word counter: clear on reset or phase end, otherwise count beats.
  always_ff @(posedge clk) begin
    if (reset) begin
      wcnt <= '0;
    end else if (beat && last) begin
      wcnt <= '0;
    end else if (beat) begin
      wcnt <= wcnt + LEN_W'(1);
    end
  end

endmodule

// File: rtl/qpsk_frame_sched.sv
// Frame scheduler in front of the QPSK repeater: preamble, payload, then
// zero guard words, sharing one stream input with no added data latency.
//
// state | meaning
// IDLE  | no frame; sources stalled, out_tvalid low, waits for start
// PRE   | preamble source muxed straight to the repeater
// PAY   | payload source muxed straight to the repeater
// GAP   | zero guard words, out_tvalid held high
//
// Optional build macro QPSK_SCHED_STATS_EN adds frame_cnt and stall_cnt.
module qpsk_frame_sched
  import qpsk_sched_pkg::*;
#(
  parameter int DW    = 32,
  parameter int LEN_W = LEN_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [LEN_W-1:0] pre_len,
  input  logic [LEN_W-1:0] pay_len,
  input  logic [LEN_W-1:0] gap_len,
  input  logic [DW-1:0]    pre_tdata,
  input  logic             pre_tvalid,
  output logic             pre_tready,
  input  logic [DW-1:0]    pay_tdata,
  input  logic             pay_tvalid,
  output logic             pay_tready,
  output logic [DW-1:0]    out_tdata,
  output logic             out_tvalid,
  input  logic             out_tready,
  output logic             busy,
  output logic             frame_done,
  output logic [3:0]       sched_state
`ifdef QPSK_SCHED_STATS_EN
  ,
  output logic [15:0]      frame_cnt,
  output logic [31:0]      stall_cnt
`endif
);

  sched_state_t     state, state_nxt;
  logic             done_nxt;
  logic [LEN_W-1:0] pre_len_q, pay_len_q, gap_len_q;
  logic [LEN_W-1:0] cur_len;
  logic             beat, last_beat, phase_end;

  assign beat        = out_tvalid && out_tready;
  assign phase_end   = beat && last_beat;
  assign busy        = (state != ST_IDLE);
  assign sched_state = state;

  sched_phase_cnt #(.LEN_W(LEN_W)) u_phase_cnt (
    .clk   (clk),
    .reset (reset),
    .beat  (beat),
    .len   (cur_len),
    .last  (last_beat)
  );

  // State register and the registered end-of-frame pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      frame_done <= done_nxt;
    end
  end

  // Lengths are frozen for the whole frame once start is accepted.
  always_ff @(posedge clk) begin
    if (reset) begin
      pre_len_q <= '0;
      pay_len_q <= '0;
      gap_len_q <= '0;
    end else if ((state == ST_IDLE) && start) begin
      pre_len_q <= pre_len;
      pay_len_q <= pay_len;
      gap_len_q <= gap_len;
    end
  end

  // Next state: IDLE looks at the live length inputs (they are being latched
  // this cycle); running phases look at the latched copies.
  always_comb begin
    state_nxt = state;
    done_nxt  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt = next_phase(ST_IDLE, pre_len != '0, pay_len != '0, gap_len != '0);
          done_nxt  = (pre_len == '0) && (pay_len == '0) && (gap_len == '0);
        end
      end
      ST_PRE, ST_PAY, ST_GAP: begin
        if (phase_end) begin
          state_nxt = next_phase(state, pre_len_q != '0, pay_len_q != '0, gap_len_q != '0);
          done_nxt  = (state_nxt == ST_IDLE);
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Output mux: only the selected source ever sees tready.
  always_comb begin
    out_tdata  = '0;
    out_tvalid = 1'b0;
    pre_tready = 1'b0;
    pay_tready = 1'b0;
    cur_len    = '0;
    case (state)
      ST_PRE: begin
        out_tdata  = pre_tdata;
        out_tvalid = pre_tvalid;
        pre_tready = out_tready;
        cur_len    = pre_len_q;
      end
      ST_PAY: begin
        out_tdata  = pay_tdata;
        out_tvalid = pay_tvalid;
        pay_tready = out_tready;
        cur_len    = pay_len_q;
      end
      ST_GAP: begin
        out_tvalid = 1'b1;
        cur_len    = gap_len_q;
      end
      default: ;
    endcase
  end

`ifdef QPSK_SCHED_STATS_EN
  // Completed-frame counter, wraps at 16 bits.
  always_ff @(posedge clk) begin
    if (reset)           frame_cnt <= '0;
    else if (frame_done) frame_cnt <= frame_cnt + 16'd1;
  end

  // Source-starved cycles in PRE/PAY, saturating.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (((state == ST_PRE) || (state == ST_PAY)) && !out_tvalid
                 && (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_qpsk_frame_sched.sv
// Bench for qpsk_frame_sched: a beat-queue model of the frame plus directed
// scenarios with hand-computed totals. Optional QPSK_SCHED_STATS_EN adds
// checks of frame_cnt and stall_cnt.
module tb_qpsk_frame_sched;

  logic        clk;
  logic        reset;
  logic        start;
  logic [15:0] pre_len, pay_len, gap_len;
  logic [31:0] pre_tdata, pay_tdata;
  logic        pre_tvalid, pay_tvalid;
  logic        pre_tready, pay_tready;
  logic [31:0] out_tdata;
  logic        out_tvalid, out_tready;
  logic        busy, frame_done;
  logic [3:0]  sched_state;
`ifdef QPSK_SCHED_STATS_EN
  logic [15:0] frame_cnt;
  logic [31:0] stall_cnt;
`endif

  qpsk_frame_sched #(.DW(32), .LEN_W(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .pre_len    (pre_len),
    .pay_len    (pay_len),
    .gap_len    (gap_len),
    .pre_tdata  (pre_tdata),
    .pre_tvalid (pre_tvalid),
    .pre_tready (pre_tready),
    .pay_tdata  (pay_tdata),
    .pay_tvalid (pay_tvalid),
    .pay_tready (pay_tready),
    .out_tdata  (out_tdata),
    .out_tvalid (out_tvalid),
    .out_tready (out_tready),
    .busy       (busy),
    .frame_done (frame_done),
    .sched_state(sched_state)
`ifdef QPSK_SCHED_STATS_EN
    ,
    .frame_cnt  (frame_cnt),
    .stall_cnt  (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: the frame is a queue of expected beats (1=preamble, 2=payload,
  // 3=guard). Each beat the repeater accepts pops one entry.
  int          kq[$];
  bit          exp_done = 0;
  int          exp_frames = 0;
  longint      exp_stall = 0;
  // DUT observations used for the hand-computed totals
  int          beats = 0, busy_cycles = 0, pre_rdy_cycles = 0, done_pulses = 0;
  logic [31:0] beat_q[$];
  bit          pre_hs = 0, pay_hs = 0;

  always @(negedge clk) begin
    int k;
    logic e_valid;
    logic [31:0] e_data;
    logic [3:0] e_state;
    k = (kq.size() != 0) ? kq[0] : 0;
    e_valid = (k == 1) ? pre_tvalid : (k == 2) ? pay_tvalid : (k == 3);
    e_data  = (k == 1) ? pre_tdata  : (k == 2) ? pay_tdata  : 32'd0;
    e_state = (k == 0) ? 4'b0001 : (k == 1) ? 4'b0010 : (k == 2) ? 4'b0100 : 4'b1000;

    if (chk_en) begin
      chk("out_tvalid", {31'd0, out_tvalid}, {31'd0, e_valid});
      chk("out_tdata", out_tdata, e_data);
      chk("pre_tready", {31'd0, pre_tready}, {31'd0, (k == 1) && out_tready});
      chk("pay_tready", {31'd0, pay_tready}, {31'd0, (k == 2) && out_tready});
      chk("busy", {31'd0, busy}, {31'd0, k != 0});
      chk("frame_done", {31'd0, frame_done}, {31'd0, exp_done});
      chk("sched_state", {28'd0, sched_state}, {28'd0, e_state});
`ifdef QPSK_SCHED_STATS_EN
      chk("frame_cnt", {16'd0, frame_cnt}, {16'd0, exp_frames[15:0]});
      chk("stall_cnt", stall_cnt, exp_stall[31:0]);
`endif
    end

    if (out_tvalid && out_tready) begin
      beats++;
      beat_q.push_back(out_tdata);
    end
    if (busy) busy_cycles++;
    if (pre_tready) pre_rdy_cycles++;
    if (frame_done) done_pulses++;
    pre_hs = pre_tvalid && pre_tready;
    pay_hs = pay_tvalid && pay_tready;

    // advance the model to what must hold after the coming rising edge
    if (reset) begin
      kq.delete();
      exp_done   = 0;
      exp_frames = 0;
      exp_stall  = 0;
    end else begin
      if (exp_done) exp_frames++;
      if ((k == 1 || k == 2) && !e_valid && exp_stall < 64'hFFFF_FFFF) exp_stall++;
      exp_done = 0;
      if (k == 0) begin
        if (start) begin
          for (int i = 0; i < int'(pre_len); i++) kq.push_back(1);
          for (int i = 0; i < int'(pay_len); i++) kq.push_back(2);
          for (int i = 0; i < int'(gap_len); i++) kq.push_back(3);
          if (kq.size() == 0) exp_done = 1;
        end
      end else if (e_valid && out_tready) begin
        void'(kq.pop_front());
        if (kq.size() == 0) exp_done = 1;
      end
    end
  end

  // Sources present the next word after each accepted one.
  always @(posedge clk) begin
    bit a_pre, a_pay;
    a_pre = pre_hs;
    a_pay = pay_hs;
    #1;
    if (a_pre) pre_tdata = pre_tdata + 32'd1;
    if (a_pay) pay_tdata = pay_tdata + 32'd1;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic start_frame(input int p, input int y, input int g);
    pre_len = 16'(p);
    pay_len = 16'(y);
    gap_len = 16'(g);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(input int max_cyc);
    int i = 0;
    while (busy && i < max_cyc) begin
      tick();
      i++;
    end
    chk("wait_idle_timeout", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1, "watchdog");
  end

  int b0, bz0, pr0, d0, q0;
  logic [31:0] pre0, pay0;

  initial begin
    reset = 1'b1; start = 1'b0;
    pre_len = '0; pay_len = '0; gap_len = '0;
    pre_tdata = 32'hA000_0000; pay_tdata = 32'hB000_0000;
    pre_tvalid = 1'b1; pay_tvalid = 1'b1; out_tready = 1'b1;
    tick(); tick();
    chk_en = 1;
    reset = 1'b0;
    tick();
    chk("rst_state", {28'd0, sched_state}, 32'h1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_out_tvalid", {31'd0, out_tvalid}, 32'd0);
    chk("rst_out_tdata", out_tdata, 32'd0);

    // 2 preamble + 3 payload + 4 guard, everything ready
    b0 = beats; bz0 = busy_cycles; d0 = done_pulses; q0 = beat_q.size();
    pre0 = pre_tdata; pay0 = pay_tdata;
    start_frame(2, 3, 4);
    wait_idle(50);
    tick(); tick();
    chk("t1_beats", beats - b0, 9);
    chk("t1_busy_cycles", busy_cycles - bz0, 9);
    chk("t1_done_pulses", done_pulses - d0, 1);
    chk("t1_pre_words", pre_tdata - pre0, 2);
    chk("t1_pay_words", pay_tdata - pay0, 3);
    chk("t1_beat2", beat_q[q0 + 2], 32'hB000_0000);
    chk("t1_beat8", beat_q[q0 + 8], 32'h0);

    // preamble skipped
    b0 = beats; pr0 = pre_rdy_cycles; d0 = done_pulses; pay0 = pay_tdata;
    start_frame(0, 2, 0);
    wait_idle(50);
    tick(); tick();
    chk("t2_beats", beats - b0, 2);
    chk("t2_pre_ready_cycles", pre_rdy_cycles - pr0, 0);
    chk("t2_pay_words", pay_tdata - pay0, 2);
    chk("t2_done_pulses", done_pulses - d0, 1);

    // empty frame
    b0 = beats; bz0 = busy_cycles; d0 = done_pulses;
    start_frame(0, 0, 0);
    chk("t3_done_next_cycle", {31'd0, frame_done}, 32'd1);
    tick(); tick();
    chk("t3_beats", beats - b0, 0);
    chk("t3_busy_cycles", busy_cycles - bz0, 0);
    chk("t3_done_pulses", done_pulses - d0, 1);

    // repeater ready toggling during payload
    b0 = beats; q0 = beat_q.size(); pay0 = pay_tdata;
    start_frame(0, 4, 0);
    for (int i = 0; i < 40 && busy; i++) begin
      out_tready = (i % 2 == 0);
      tick();
    end
    out_tready = 1'b1;
    chk("t4_idle", {31'd0, busy}, 32'd0);
    tick();
    chk("t4_beats", beats - b0, 4);
    chk("t4_pay_words", pay_tdata - pay0, 4);
    for (int i = 0; i < 4; i++)
      chk("t4_order", beat_q[q0 + i], pay0 + 32'(i));

    // reset mid-payload
    d0 = done_pulses;
    start_frame(0, 3, 0);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t5_state_idle", {28'd0, sched_state}, 32'h1);
    chk("t5_pre_ready", {31'd0, pre_tready}, 32'd0);
    chk("t5_pay_ready", {31'd0, pay_tready}, 32'd0);
    chk("t5_out_tvalid", {31'd0, out_tvalid}, 32'd0);
    tick(); tick();
    chk("t5_no_done", done_pulses - d0, 0);
    b0 = beats;
    start_frame(0, 1, 0);
    wait_idle(20);
    tick();
    chk("t5_one_beat", beats - b0, 1);

    // back-to-back: start accepted in the frame_done cycle
    b0 = beats; d0 = done_pulses;
    start_frame(1, 0, 1);
    for (int i = 0; i < 50 && !frame_done; i++) tick();
    chk("t6_done_seen", {31'd0, frame_done}, 32'd1);
    start_frame(0, 0, 2);
    wait_idle(50);
    tick(); tick();
    chk("t6_beats", beats - b0, 4);
    chk("t6_done_pulses", done_pulses - d0, 2);

    // preamble source stalling, start pulsed while busy (ignored)
    b0 = beats; pre0 = pre_tdata;
    start_frame(3, 0, 2);
    for (int i = 0; i < 60 && busy; i++) begin
      pre_tvalid = (i % 3 != 1);
      start = (i == 2);
      tick();
    end
    start = 1'b0;
    pre_tvalid = 1'b1;
    tick(); tick();
    chk("t7_beats", beats - b0, 5);
    chk("t7_pre_words", pre_tdata - pre0, 3);
    chk("t7_idle", {31'd0, busy}, 32'd0);

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
